// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: memory port request/response, FIFO entry and drain FSM states.
package store_buffer_pkg;

  localparam int SB_DEPTH   = 8;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wr_data;
    logic                  MemWrite;
    logic                  MemRead;
    logic                  valid;
  } memReqStruct;

  typedef struct packed {
    logic [MEM_DATA_W-1:0] rd_data;
    logic                  MemRead;
    logic                  valid;
  } memRespStruct;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
  } sbEntryStruct;

  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_WAIT = 1'b1
  } sbState;

endpackage

// File: rtl/sb_fwd_cam.sv
// Youngest-match search over the occupied store buffer entries (store-to-load forwarding).
// Only present when STORE_FWD_EN is defined.
`ifdef STORE_FWD_EN
module sb_fwd_cam
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  sbEntryStruct                 entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]     head,
  input  logic [$clog2(DEPTH+1)-1:0]   count,
  input  logic [ADDR_W-1:0]            ld_addr,
  output logic                         fwd_hit,
  output logic [DATA_W-1:0]            fwd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (entries[idx].addr == MEM_ADDR_W'(ld_addr))) begin
        fwd_hit  = 1'b1;
        fwd_data = DATA_W'(entries[idx].data);
      end
    end
  end

endmodule
`endif

// File: rtl/store_buffer.sv
// Retired-store FIFO draining to memory in program order, one write outstanding at a time.
// Optional store-to-load forwarding port is enabled with the STORE_FWD_EN macro.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        commit_valid,
  input  logic [ADDR_W-1:0]           commit_addr,
  input  logic [DATA_W-1:0]           commit_data,
  input  logic                        ld_busy,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        err_overflow,
`ifdef STORE_FWD_EN
  input  logic [ADDR_W-1:0]           ld_addr,
  output logic                        fwd_hit,
  output logic [DATA_W-1:0]           fwd_data,
`endif
  output memReqStruct                 request,
  input  memRespStruct                response
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  sbEntryStruct     entries [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  sbState           state;
  sbState           state_nxt;
  logic             enq;
  logic             launch;
  logic             pop;
  logic             unused_rd;

  assign unused_rd = ^response.rd_data;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  // Pre-edge full blocks the commit even if the same edge pops.
  assign enq   = commit_valid && !full;

  // Entry payload is not reset; validity comes from head/count.
  always_ff @(posedge clk) begin
    if (enq) begin
      entries[tail] <= '{addr: MEM_ADDR_W'(commit_addr), data: MEM_DATA_W'(commit_data)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (pop) head <= head + PTR_W'(1);
      case ({enq, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (commit_valid && full) err_overflow <= 1'b1;
    end
  end

  // Drain FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SB_IDLE;
    else        state <= state_nxt;
  end

  // Drain FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      SB_IDLE: if (!empty && !ld_busy) state_nxt = SB_WAIT;
      SB_WAIT: if (response.valid && !response.MemRead) state_nxt = SB_IDLE;
      default: state_nxt = SB_IDLE;
    endcase
  end

  // Drain FSM: outputs; load responses (MemRead=1) never count as a write ack.
  always_comb begin
    launch = 1'b0;
    pop    = 1'b0;
    case (state)
      SB_IDLE: launch = !empty && !ld_busy;
      SB_WAIT: pop    = response.valid && !response.MemRead;
      default: ;
    endcase
  end

  // valid pulses for one cycle; address and data hold until the next launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      request <= '0;
    end else begin
      request.valid <= launch;
      if (launch) begin
        request.addr     <= entries[head].addr;
        request.wr_data  <= entries[head].data;
        request.MemWrite <= 1'b1;
        request.MemRead  <= 1'b0;
      end
    end
  end

`ifdef STORE_FWD_EN
  sb_fwd_cam #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fwd_cam (
    .entries  (entries),
    .head     (head),
    .count    (count),
    .ld_addr  (ld_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data)
  );
`else
  // Without forwarding, loads always read memory; no address compare exists.
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer; inputs driven and outputs sampled on the falling edge.
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         commit_valid;
  logic [31:0]  commit_addr;
  logic [31:0]  commit_data;
  logic         ld_busy;
  logic         full;
  logic         empty;
  logic [3:0]   count;
  logic         err_overflow;
  memReqStruct  request;
  memRespStruct response;
`ifdef STORE_FWD_EN
  logic [31:0]  ld_addr;
  logic         fwd_hit;
  logic [31:0]  fwd_data;
`endif

  int checks;
  int errors;

  store_buffer #(.DEPTH(8), .ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .commit_valid (commit_valid),
    .commit_addr  (commit_addr),
    .commit_data  (commit_data),
    .ld_busy      (ld_busy),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .err_overflow (err_overflow),
`ifdef STORE_FWD_EN
    .ld_addr      (ld_addr),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data),
`endif
    .request      (request),
    .response     (response)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    commit_valid = 1'b0;
    commit_addr  = '0;
    commit_data  = '0;
    ld_busy      = 1'b0;
    response     = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    commit_valid = 1'b1;
    commit_addr  = a;
    commit_data  = d;
    @(negedge clk);
    commit_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; commit_valid = 1'b0; commit_addr = '0; commit_data = '0;
    ld_busy = 1'b0; response = '0;
`ifdef STORE_FWD_EN
    ld_addr = '0;
`endif
    @(negedge clk); @(negedge clk);
    checks++; if (count !== 4'd0) begin $display("FAIL reset_count got=%0d exp=0", count); errors++; end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin $display("FAIL reset_flags empty=%b full=%b exp 1/0", empty, full); errors++; end
    checks++; if (err_overflow !== 1'b0) begin $display("FAIL reset_err got=%b exp=0", err_overflow); errors++; end
    checks++; if (request !== '0) begin $display("FAIL reset_request got=%h exp=0", request); errors++; end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    do_reset();
    push(32'h100, 32'hDEADBEEF);
    checks++; if (count !== 4'd1 || request.valid !== 1'b0) begin $display("FAIL single_enq count=%0d valid=%b exp 1/0", count, request.valid); errors++; end
    @(negedge clk);
    checks++; if (request.valid !== 1'b1 || request.MemWrite !== 1'b1 || request.MemRead !== 1'b0) begin
      $display("FAIL single_req valid=%b wr=%b rd=%b exp 1/1/0", request.valid, request.MemWrite, request.MemRead); errors++; end
    checks++; if (request.addr !== 32'h100 || request.wr_data !== 32'hDEADBEEF) begin
      $display("FAIL single_payload addr=%h data=%h exp 100/deadbeef", request.addr, request.wr_data); errors++; end
    @(negedge clk);
    checks++; if (request.valid !== 1'b0 || request.addr !== 32'h100) begin
      $display("FAIL single_pulse valid=%b addr=%h exp 0/100", request.valid, request.addr); errors++; end
    @(negedge clk);
    response = '{rd_data: '0, MemRead: 1'b0, valid: 1'b1};
    @(negedge clk);
    response = '0;
    checks++; if (count !== 4'd0 || empty !== 1'b1) begin $display("FAIL single_ack count=%0d empty=%b exp 0/1", count, empty); errors++; end
  endtask

  task automatic test_fill();
    int n;
    do_reset();
    ld_busy = 1'b1;
    for (int i = 0; i < 8; i++) push(32'(i * 4), 32'(i));
    checks++; if (full !== 1'b1 || count !== 4'd8) begin $display("FAIL fill_full full=%b count=%0d exp 1/8", full, count); errors++; end
    checks++; if (err_overflow !== 1'b0) begin $display("FAIL fill_err_early got=%b exp=0", err_overflow); errors++; end
    push(32'h20, 32'd8);
    checks++; if (err_overflow !== 1'b1 || count !== 4'd8) begin $display("FAIL overflow err=%b count=%0d exp 1/8", err_overflow, count); errors++; end
    ld_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (request.valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      checks++;
      if (n >= 10) begin $display("FAIL drain_timeout entry=%0d valid=%b exp 1", i, request.valid); errors++; end
      else if (request.addr !== 32'(i * 4) || request.wr_data !== 32'(i)) begin
        $display("FAIL drain_order entry=%0d addr=%h data=%h exp %h/%h", i, request.addr, request.wr_data, i * 4, i); errors++; end
      response = '{rd_data: '0, MemRead: 1'b0, valid: 1'b1};
      @(negedge clk);
      response = '0;
    end
    checks++; if (count !== 4'd0 || empty !== 1'b1 || err_overflow !== 1'b1) begin
      $display("FAIL drain_end count=%0d empty=%b err=%b exp 0/1/1", count, empty, err_overflow); errors++; end
  endtask

  task automatic test_ld_busy();
    do_reset();
    ld_busy = 1'b1;
    push(32'h200, 32'h55);
    for (int i = 0; i < 5; i++) begin
      checks++; if (request.valid !== 1'b0) begin $display("FAIL busy_block cycle=%0d valid=%b exp 0", i, request.valid); errors++; end
      @(negedge clk);
    end
    ld_busy = 1'b0;
    @(negedge clk);
    checks++; if (request.valid !== 1'b1 || request.addr !== 32'h200) begin
      $display("FAIL busy_launch valid=%b addr=%h exp 1/200", request.valid, request.addr); errors++; end
    ld_busy  = 1'b1;
    response = '{rd_data: 32'hABCD, MemRead: 1'b1, valid: 1'b1};
    @(negedge clk);
    response = '0;
    checks++; if (count !== 4'd1) begin $display("FAIL load_resp_pop count=%0d exp 1", count); errors++; end
    response = '{rd_data: '0, MemRead: 1'b0, valid: 1'b1};
    @(negedge clk);
    response = '0;
    ld_busy  = 1'b0;
    checks++; if (count !== 4'd0) begin $display("FAIL busy_ack count=%0d exp 0", count); errors++; end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ld_busy = 1'b1;
    push(32'h300, 32'hA0);
    push(32'h304, 32'hA1);
    push(32'h308, 32'hA2);
    ld_busy = 1'b0;
    @(negedge clk);
    checks++; if (request.valid !== 1'b1 || request.addr !== 32'h300 || count !== 4'd3) begin
      $display("FAIL b2b_first valid=%b addr=%h count=%0d exp 1/300/3", request.valid, request.addr, count); errors++; end
    commit_valid = 1'b1; commit_addr = 32'h30C; commit_data = 32'hA3;
    response = '{rd_data: '0, MemRead: 1'b0, valid: 1'b1};
    @(negedge clk);
    commit_valid = 1'b0;
    response     = '0;
    checks++; if (count !== 4'd3 || request.valid !== 1'b0) begin
      $display("FAIL b2b_same_edge count=%0d valid=%b exp 3/0", count, request.valid); errors++; end
    @(negedge clk);
    checks++; if (request.valid !== 1'b1 || request.addr !== 32'h304 || request.wr_data !== 32'hA1) begin
      $display("FAIL b2b_next valid=%b addr=%h data=%h exp 1/304/a1", request.valid, request.addr, request.wr_data); errors++; end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ld_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h400 + 32'(i * 4), 32'(i));
    ld_busy = 1'b0;
    @(negedge clk);
    checks++; if (request.valid !== 1'b1 || count !== 4'd4) begin
      $display("FAIL mid_launch valid=%b count=%0d exp 1/4", request.valid, count); errors++; end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 4'd0 || request !== '0) begin
      $display("FAIL mid_async count=%0d request=%h exp 0/0", count, request); errors++; end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    response = '{rd_data: '0, MemRead: 1'b0, valid: 1'b1};
    @(negedge clk);
    response = '0;
    checks++; if (count !== 4'd0 || empty !== 1'b1 || request.valid !== 1'b0) begin
      $display("FAIL mid_late_ack count=%0d empty=%b valid=%b exp 0/1/0", count, empty, request.valid); errors++; end
  endtask

`ifdef STORE_FWD_EN
  task automatic test_fwd();
    do_reset();
    ld_busy = 1'b1;
    push(32'h40, 32'h11);
    push(32'h40, 32'h22);
    push(32'h48, 32'h33);
    ld_addr = 32'h40;
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h22) begin
      $display("FAIL fwd_youngest hit=%b data=%h exp 1/22", fwd_hit, fwd_data); errors++; end
    ld_addr = 32'h44;
    #1;
    checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin
      $display("FAIL fwd_miss hit=%b data=%h exp 0/0", fwd_hit, fwd_data); errors++; end
    ld_addr = 32'h48;
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h33) begin
      $display("FAIL fwd_other hit=%b data=%h exp 1/33", fwd_hit, fwd_data); errors++; end
    ld_busy = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_fill();
    test_ld_busy();
    test_back_to_back();
    test_reset_mid();
`ifdef STORE_FWD_EN
    test_fwd();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
